// File: rtl/poli_crc_engine.sv
// POLI CRC-32 engine: words are queued from CRC_INPUT writes and folded in MSB byte first, one byte per cycle.
// Latency: 5 cycles from an input write to DONE. Backpressure: none; a write while the FIFO is full is dropped and flagged.
package poli_pkg;
    typedef enum logic [3:0] {
        REG_NONE    = 4'h0,
        GPIO_DATA   = 4'h1,
        GPIO_DIR    = 4'h2,
        TIMER_COUNT = 4'h3,
        CRC_CONTROL = 4'h4,
        CRC_STATUS  = 4'h5,
        CRC_INPUT   = 4'h6,
        CRC_OUTPUT  = 4'h7
    } regsel_t;
endpackage

// Generic synchronous FIFO with a flush input and an occupancy count.
// Latency: one cycle from push to visible head. Backpressure: in_rdy drops when full.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          flush,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [W-1:0]  in_dat,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [W-1:0]  out_dat,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Full is judged on the count before any same-cycle pop.
    assign in_rdy  = (count != CW'(DEPTH));
    assign out_vld = (count != '0);
    assign out_dat = mem[rd_ptr];
    assign push    = in_vld & in_rdy;
    assign pop     = out_rdy & out_vld;

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= in_dat;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end
endmodule

module poli_crc_engine
    import poli_pkg::*;
#(
    parameter int                   WORD_SIZE  = 32,
    parameter logic [WORD_SIZE-1:0] POLY       = 32'h04C11DB7,
    parameter int                   FIFO_DEPTH = 4,
    localparam int                  CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  regsel_t              register_select,
    input  logic                 write_enable,
    input  logic [WORD_SIZE-1:0] write_data,
    output logic [WORD_SIZE-1:0] read_data,
    output logic                 irq
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_nxt;
    logic [1:0]           beat, beat_nxt;
    logic [WORD_SIZE-1:0] shift, shift_nxt;
    logic [WORD_SIZE-1:0] crc, crc_nxt;
    logic                 seed_ones, irq_en, done, ovf;
    logic                 done_nxt, irq_en_nxt;

    logic                 ctrl_wr, status_wr, input_wr, init;
    logic                 pop, set_done, full, busy;
    logic                 fifo_in_rdy, fifo_out_vld;
    logic [WORD_SIZE-1:0] fifo_out_dat;
    logic [CW-1:0]        fifo_count;
    logic [WORD_SIZE-1:0] rd_mux;

    function automatic logic [WORD_SIZE-1:0] step8(input logic [WORD_SIZE-1:0] c, input logic [7:0] b);
        logic [WORD_SIZE-1:0] r;
        r = c ^ {b, {(WORD_SIZE-8){1'b0}}};
        for (int i = 0; i < 8; i++) begin
            r = r[WORD_SIZE-1] ? ((r << 1) ^ POLY) : (r << 1);
        end
        return r;
    endfunction

    assign ctrl_wr   = write_enable && (register_select == CRC_CONTROL);
    assign status_wr = write_enable && (register_select == CRC_STATUS);
    assign input_wr  = write_enable && (register_select == CRC_INPUT);
    assign init      = ctrl_wr && write_data[0];
    assign full      = ~fifo_in_rdy;
    assign busy      = (state != IDLE) || (fifo_count != '0);

    sync_fifo #(.W(WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK     (CLK),
        .nRST    (nRST),
        .flush   (init),
        .in_vld  (input_wr),
        .in_rdy  (fifo_in_rdy),
        .in_dat  (write_data),
        .out_vld (fifo_out_vld),
        .out_rdy (pop),
        .out_dat (fifo_out_dat),
        .count   (fifo_count)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            beat  <= '0;
            shift <= '0;
            crc   <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            shift <= shift_nxt;
            crc   <= crc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        shift_nxt = shift;
        crc_nxt   = crc;
        pop       = 1'b0;
        set_done  = 1'b0;
        if (init) begin
            state_nxt = IDLE;
            beat_nxt  = '0;
            crc_nxt   = write_data[1] ? '1 : '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_out_vld) begin
                        pop       = 1'b1;
                        shift_nxt = fifo_out_dat;
                        beat_nxt  = '0;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    crc_nxt   = step8(crc, shift[WORD_SIZE-1 -: 8]);
                    shift_nxt = shift << 8;
                    beat_nxt  = beat + 1'b1;
                    // Last byte of the word: chain straight into the next queued word if any.
                    if (beat == 2'd3) begin
                        if (fifo_out_vld) begin
                            pop       = 1'b1;
                            shift_nxt = fifo_out_dat;
                            beat_nxt  = '0;
                        end else begin
                            state_nxt = IDLE;
                            set_done  = 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign done_nxt   = init ? 1'b0 : (set_done | (done & ~(status_wr & write_data[3])));
    assign irq_en_nxt = ctrl_wr ? write_data[2] : irq_en;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            seed_ones <= 1'b0;
            irq_en    <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (ctrl_wr) seed_ones <= write_data[1];
            irq_en <= irq_en_nxt;
            done   <= done_nxt;
            if (init)                 ovf <= 1'b0;
            else if (input_wr && full) ovf <= 1'b1;
            else if (status_wr && write_data[2]) ovf <= 1'b0;
            irq <= done_nxt & irq_en_nxt;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (register_select)
            CRC_CONTROL: rd_mux = WORD_SIZE'({irq_en, seed_ones, 1'b0});
            CRC_STATUS:  rd_mux = WORD_SIZE'({3'(fifo_count), done, ovf, full, busy});
            CRC_OUTPUT:  rd_mux = crc;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) read_data <= '0;
        else       read_data <= rd_mux;
    end
endmodule

// File: tb/tb_poli_crc_engine.sv
// Directed bench for poli_crc_engine: register reads/writes through the slave-side ports, CRC checked against a bit-serial model.
module tb_poli_crc_engine;
    import poli_pkg::*;

    logic        CLK;
    logic        nRST;
    regsel_t     register_select;
    logic        write_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    poli_crc_engine dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .register_select (register_select),
        .write_enable    (write_enable),
        .write_data      (write_data),
        .read_data       (read_data),
        .irq             (irq)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Bit-serial reference: one message bit per step, MSB first.
    function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] w);
        logic fb;
        for (int i = 31; i >= 0; i--) begin
            fb = c[31] ^ w[i];
            c  = c << 1;
            if (fb) c = c ^ 32'h04C11DB7;
        end
        return c;
    endfunction

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic wr(input regsel_t r, input logic [31:0] d);
        register_select = r;
        write_enable    = 1'b1;
        write_data      = d;
        @(negedge CLK);
        write_enable    = 1'b0;
        register_select = REG_NONE;
        write_data      = '0;
    endtask

    task automatic rd(input regsel_t r, output logic [31:0] d);
        register_select = r;
        write_enable    = 1'b0;
        @(negedge CLK);
        d = read_data;
        register_select = REG_NONE;
    endtask

    // Polls STATUS until BUSY is low; k is the sample index of the first idle sample.
    task automatic wait_idle(output int k, output logic [31:0] st);
        register_select = CRC_STATUS;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (read_data[0] && k < 200);
        st = read_data;
        register_select = REG_NONE;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] model;
        logic [31:0] words [6];
        int          k;

        nRST            = 1'b0;
        register_select = REG_NONE;
        write_enable    = 1'b0;
        write_data      = '0;
        repeat (3) @(negedge CLK);
        check("rst_read_data", read_data, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        nRST = 1'b1;
        @(negedge CLK);

        rd(CRC_CONTROL, v); check("rst_control", v, 32'h0);
        rd(CRC_STATUS, v);  check("rst_status", v, 32'h0);
        rd(CRC_OUTPUT, v);  check("rst_output", v, 32'h0);

        // Single word, seed 0: CRC of 0x00000001 is the polynomial itself.
        wr(CRC_CONTROL, 32'h1);
        wr(CRC_INPUT, 32'h0000_0001);
        wait_idle(k, v);
        check("one_word_busy_cycles", 32'(k - 1), 32'd5);
        check("one_word_status", v, 32'h8);
        rd(CRC_OUTPUT, v);  check("one_word_crc", v, 32'h04C1_1DB7);
        check("one_word_no_irq", {31'b0, irq}, 32'h0);

        // Seed ones with interrupt enabled.
        wr(CRC_CONTROL, 32'h7);
        wr(CRC_INPUT, 32'h0);
        k = 0;
        while (!irq && k < 50) begin
            @(negedge CLK);
            k++;
        end
        check("irq_latency", 32'(k), 32'd5);
        rd(CRC_OUTPUT, v);  check("ones_seed_crc", v, crc_word(32'hFFFF_FFFF, 32'h0));
        rd(CRC_STATUS, v);  check("ones_seed_status", v, 32'h8);
        rd(CRC_CONTROL, v); check("control_readback", v, 32'h6);
        wr(CRC_STATUS, 32'h8);
        check("irq_cleared_w1c", {31'b0, irq}, 32'h0);
        rd(CRC_STATUS, v);  check("done_cleared_w1c", v, 32'h0);

        // Six back-to-back writes: the first is popped at once, the next four fill the FIFO, the sixth is dropped.
        words[0] = 32'h1234_5678; words[1] = 32'h9ABC_DEF0; words[2] = 32'h0F0F_F0F0;
        words[3] = 32'hA5A5_5A5A; words[4] = 32'hCAFE_BABE; words[5] = 32'h1111_1111;
        wr(CRC_CONTROL, 32'h1);
        for (int i = 0; i < 6; i++) wr(CRC_INPUT, words[i]);
        wait_idle(k, v);
        check("burst_busy_cycles", 32'(k + 4), 32'd21);
        check("burst_status_ovf_done", v, 32'hC);
        model = 32'h0;
        for (int i = 0; i < 5; i++) model = crc_word(model, words[i]);
        rd(CRC_OUTPUT, v);  check("burst_crc", v, model);
        check("burst_irq_disabled", {31'b0, irq}, 32'h0);

        // INIT while the engine is mid-word with two more queued; DONE and OVERFLOW are still set from above.
        wr(CRC_INPUT, 32'hAAAA_0001);
        wr(CRC_INPUT, 32'hAAAA_0002);
        wr(CRC_INPUT, 32'hAAAA_0003);
        wr(CRC_CONTROL, 32'h3);
        rd(CRC_STATUS, v);  check("init_abort_status", v, 32'h0);
        rd(CRC_OUTPUT, v);  check("init_abort_seed", v, 32'hFFFF_FFFF);
        rd(CRC_CONTROL, v); check("init_abort_control", v, 32'h2);
        repeat (8) @(negedge CLK);
        rd(CRC_STATUS, v);  check("init_abort_stays_idle", v, 32'h0);
        rd(CRC_OUTPUT, v);  check("init_abort_crc_held", v, 32'hFFFF_FFFF);

        // Unmapped and write-ignored registers.
        rd(TIMER_COUNT, v); check("unmapped_read", v, 32'h0);
        rd(CRC_INPUT, v);   check("input_reads_zero", v, 32'h0);
        wr(CRC_OUTPUT, 32'hDEAD_BEEF);
        rd(CRC_OUTPUT, v);  check("output_write_ignored", v, 32'hFFFF_FFFF);

        // Asynchronous reset in the middle of a word.
        wr(CRC_INPUT, 32'h0000_0055);
        register_select = CRC_OUTPUT;
        repeat (2) @(negedge CLK);
        #2 nRST = 1'b0;
        #1;
        check("async_rst_read_data", read_data, 32'h0);
        check("async_rst_irq", {31'b0, irq}, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        rd(CRC_STATUS, v);  check("post_rst_status", v, 32'h0);
        rd(CRC_OUTPUT, v);  check("post_rst_output", v, 32'h0);
        rd(CRC_CONTROL, v); check("post_rst_control", v, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
